// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - parametrised bit-serial CRC generator/checker (optional macro CRC_REFLECT_EN: LSB-first feed, reversed crc_out)
module crc_engine #(
    parameter int                 CRC_W  = 8,
    parameter logic [CRC_W-1:0]   POLY   = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0]   INIT   = '0,
    parameter int                 DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              crc_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              busy
);

    // A DATA_W of 1 still needs a one-bit counter so the count register exists.
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [CRC_W-1:0]   crc;
    logic [CRC_W-1:0]   crc_next;
    logic [CRC_W-1:0]   crc_report;
    logic [DATA_W-1:0]  beat;
    logic [DATA_W-1:0]  beat_next;
    logic [CNT_W-1:0]   count;
    logic               last_q;
    logic               bit_in;
    logic               fb;

`ifdef CRC_REFLECT_EN
    // Reflected CRCs present the register with bit 0 and bit CRC_W-1 swapped end for end.
    function automatic logic [CRC_W-1:0] reverse_bits(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction
`endif

    // Pick the next data bit from the beat register and the register value after it.
    always_comb begin
`ifdef CRC_REFLECT_EN
        bit_in     = beat[0];
        beat_next  = beat >> 1;
`else
        bit_in     = beat[DATA_W-1];
        beat_next  = beat << 1;
`endif
        fb         = crc[CRC_W-1] ^ bit_in;
        crc_next   = (crc << 1) ^ (fb ? POLY : '0);
`ifdef CRC_REFLECT_EN
        crc_report = reverse_bits(crc_next);
`else
        crc_report = crc_next;
`endif
    end

    // Beats are only taken while idle, so readiness is a pure decode of the state register.
    assign in_ready = (state == IDLE);

    // Frame sequencer: accept a beat, shift it one bit per clock, report on the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            crc       <= INIT;
            beat      <= '0;
            count     <= '0;
            last_q    <= 1'b0;
            crc_valid <= 1'b0;
            crc_out   <= '0;
            crc_ok    <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            // Abort drops the partial frame but leaves the last reported result visible.
            state     <= IDLE;
            crc       <= INIT;
            count     <= '0;
            last_q    <= 1'b0;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        beat   <= in_data;
                        last_q <= in_last;
                        count  <= CNT_LOAD;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc   <= crc_next;
                    beat  <= beat_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        if (last_q) begin
                            state     <= DONE;
                            crc_valid <= 1'b1;
                            crc_out   <= crc_report;
                            crc_ok    <= (crc_next == '0);
                        end else begin
                            // CRC carries over into the next beat of the same frame.
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    crc   <= INIT;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// tb/tb_crc_engine.sv - scoreboard testbench for crc_engine (default parameters, honours CRC_REFLECT_EN)
module tb_crc_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       crc_valid;
    logic [7:0] crc_out;
    logic       crc_ok;
    logic       busy;

    crc_engine dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .crc_valid(crc_valid),
        .crc_out  (crc_out),
        .crc_ok   (crc_ok),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] crc;
        logic       ok;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frame[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         valid_seen  = 0;
    int         n_exp       = 0;
    int         last_acc    = 0;
    int         last_wait   = 0;
    logic [7:0] last_exp_crc = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, by long division over the fed bit string.
    function automatic logic [7:0] model_rem();
        bit         bits[$];
        logic [8:0] r;
        r = 9'h000;
        foreach (frame[i]) begin
            for (int k = 0; k < 8; k++) begin
`ifdef CRC_REFLECT_EN
                bits.push_back(frame[i][k]);
`else
                bits.push_back(frame[i][7-k]);
`endif
            end
        end
        for (int k = 0; k < 8; k++) bits.push_back(1'b0);
        foreach (bits[j]) begin
            r = {r[7:0], bits[j]};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] shown(input logic [7:0] r);
`ifdef CRC_REFLECT_EN
        return rev8(r);
`else
        return r;
`endif
    endfunction

    // Monitor: every crc_valid pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && crc_valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                check("unexpected_crc_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("crc_out", 32'(crc_out), 32'(e.crc));
                check("crc_ok", 32'(crc_ok), 32'(e.ok));
                check("latency", 32'(cyc + 1 - e.acc), 32'd9);
            end
        end
    end

    // Present one beat at a negedge and wait (bounded) for it to be taken.
    task automatic send_beat(input logic [7:0] d, input logic l, input bit hold);
        int         t;
        logic [7:0] r;
        exp_t       e;
        t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            last_acc = cyc + 1;
            frame.push_back(d);
            if (l) begin
                r     = model_rem();
                e.crc = shown(r);
                e.ok  = (r == 8'h00);
                e.acc = last_acc;
                sb.push_back(e);
                n_exp++;
                last_exp_crc = e.crc;
                frame.delete();
            end
        end
        @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int         a0;
        int         a1;
        int         nb;
        logic [7:0] app;

        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_crc_valid", 32'(crc_valid), 32'd0);
        check("rst_crc_out", 32'(crc_out), 32'd0);
        check("rst_crc_ok", 32'(crc_ok), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // "123456789"
        for (int i = 0; i < 9; i++) send_beat(8'h31 + 8'(i), (i == 8), 1'b0);
        idle(12);
        check("busy_after_frame", 32'(busy), 32'd0);

        // Single-beat frames
        send_beat(8'h01, 1'b1, 1'b0);
        idle(10);
        send_beat(8'hFF, 1'b1, 1'b0);
        idle(10);
`ifdef CRC_REFLECT_EN
        send_beat(8'h80, 1'b1, 1'b0);
        idle(10);
`endif

        // Frame followed by its own CRC must leave a zero residue
        for (int i = 0; i < 9; i++) send_beat(8'h31 + 8'(i), 1'b0, 1'b0);
        app = shown(model_rem());
        send_beat(app, 1'b1, 1'b0);
        idle(12);

        // Continuous in_valid, 3-beat frame
        send_beat(8'h12, 1'b0, 1'b1);
        a0 = last_acc;
        send_beat(8'h34, 1'b0, 1'b1);
        a1 = last_acc;
        check("ready_low_cycles_b2", 32'(last_wait), 32'd8);
        check("accept_gap_b2", 32'(a1 - a0), 32'd9);
        send_beat(8'h56, 1'b1, 1'b0);
        check("ready_low_cycles_b3", 32'(last_wait), 32'd8);
        check("accept_gap_b3", 32'(last_acc - a1), 32'd9);
        idle(12);
        send_beat(8'h12, 1'b0, 1'b0);
        send_beat(8'h34, 1'b0, 1'b0);
        send_beat(8'h56, 1'b1, 1'b0);
        idle(12);

        // Clear after beat 2 of 4, then a fresh frame
        send_beat(8'hA5, 1'b0, 1'b0);
        send_beat(8'h5A, 1'b0, 1'b0);
        idle(2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        frame.delete();
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_ready", 32'(in_ready), 32'd1);
        check("clear_keeps_crc_out", 32'(crc_out), 32'(last_exp_crc));
        send_beat(8'h01, 1'b1, 1'b0);
        idle(12);

        // Same with reset
        send_beat(8'hA5, 1'b0, 1'b0);
        send_beat(8'h5A, 1'b0, 1'b0);
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame.delete();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_crc_out", 32'(crc_out), 32'd0);
        send_beat(8'h01, 1'b1, 1'b0);
        idle(12);

        // clear together with an offered beat cancels the accept
        in_data  = 8'h33;
        in_last  = 1'b1;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_cancel_busy", 32'(busy), 32'd0);
        check("clear_cancel_ready", 32'(in_ready), 32'd1);
        send_beat(8'h01, 1'b1, 1'b0);
        idle(12);

        // Randomised frames
        for (int f = 0; f < 25; f++) begin
            nb = int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
                send_beat(8'($urandom), (b == nb - 1), 1'($urandom));
                idle(int'($urandom_range(0, 3)));
            end
            in_valid = 1'b0;
            idle(int'($urandom_range(0, 2)));
        end

        for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("crc_valid_count", 32'(valid_seen), 32'(n_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
